lfsr_bank: RTL and testbench

Multi-channel, parametrised Galois LFSR generator. It is the successor to the single-channel LFSR application block inside the AFU. It holds `CH` independent channels of width `N`, all programmed through the same `W`/`A`/`D` write port. Each channel has its own polynomial, seed, control and burst-count registers, and adds a counted BURST mode, a per-channel done pulse and zero-state lockup detection.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_channel.sv | 128 ++++++++++++
 rtl/lfsr_bank.sv | 72 +++++++
 tb/tb_lfsr_bank.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//   Shared types and constants for the multi-channel Galois LFSR bank.
//   - lfsr_mode_e : channel mode; the encoding equals the CTRL write code
//                   (D[1:0]) so a CTRL write casts straight into the state.
//   - OFS_*       : register offsets inside one channel's address window.
//   - CH_STRIDE   : size of one channel's address window.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STEP  = 2'b01,
        RUN   = 2'b10,
        BURST = 2'b11
    } lfsr_mode_e;

    localparam logic [2:0] OFS_POLY  = 3'd0;
    localparam logic [2:0] OFS_SEED  = 3'd2;
    localparam logic [2:0] OFS_CTRL  = 3'd4;
    localparam logic [2:0] OFS_COUNT = 3'd6;

    localparam int CH_STRIDE = 8;

    // A channel is active (advancing or about to finish a burst) in every
    // mode except IDLE.
    function automatic logic mode_active(input lfsr_mode_e m);
        return m != IDLE;
    endfunction

endpackage

// File: rtl/lfsr_channel.sv
// -----------------------------------------------------------------------------
// lfsr_channel
//   One Galois LFSR channel: POLY, SEED/LFSR, COUNT registers, the mode FSM,
//   the burst remaining counter and the registered done/lockup flags.
//
//   Ports:
//     clock, reset        : rising-edge clock, async active-high reset
//     we_poly/we_seed/
//     we_ctrl/we_count    : one-cycle write strobes (at most one per cycle)
//     d     [N-1:0]       : write data (CTRL uses d[1:0])
//     q     [N-1:0]       : current LFSR value
//     state               : current mode (also the debug view of the FSM)
//     done                : one-cycle pulse after a burst completes
//     lockup              : LFSR was zero while active, one edge ago
// -----------------------------------------------------------------------------
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         we_poly,
    input  logic         we_seed,
    input  logic         we_ctrl,
    input  logic         we_count,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output lfsr_mode_e   state,
    output logic         done,
    output logic         lockup
);

    lfsr_mode_e   state_q,  state_d;
    logic [N-1:0] lfsr_q,   lfsr_d;
    logic [N-1:0] poly_q,   poly_d;
    logic [N-1:0] count_q,  count_d;
    logic [N-1:0] rem_q,    rem_d;
    logic         done_q,   done_d;
    logic         lockup_q, lockup_d;
    logic         advance;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        poly_d   = poly_q;
        count_d  = count_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        lockup_d = (lfsr_q == '0) && mode_active(state_q);

        case (state_q)
            RUN: begin
                advance = 1'b1;
            end
            STEP: begin
                advance = 1'b1;
                state_d = IDLE;
            end
            BURST: begin
                // A burst entered with COUNT = 0 finishes without advancing.
                if (rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    advance = 1'b1;
                    rem_d   = rem_q - N'(1);
                    if (rem_q == N'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (advance) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? poly_q : '0);
        end

        // A seed load wins over this edge's advance; the burst count still
        // decrements because the FSM path above is left untouched.
        if (we_seed) begin
            lfsr_d = d;
        end
        if (we_poly) begin
            poly_d = d;
        end
        if (we_count) begin
            count_d = d;
        end

        // A CTRL write replaces whatever the FSM decided: an aborted burst
        // produces no done, and re-entering BURST reloads the counter.
        if (we_ctrl) begin
            state_d = lfsr_mode_e'(d[1:0]);
            done_d  = 1'b0;
            rem_d   = (lfsr_mode_e'(d[1:0]) == BURST) ? count_q : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= '0;
            poly_q   <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            poly_q   <= poly_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
        end
    end

    assign q      = lfsr_q;
    assign state  = state_q;
    assign done   = done_q;
    assign lockup = lockup_q;

endmodule

// File: rtl/lfsr_bank.sv
// -----------------------------------------------------------------------------
// lfsr_bank
//   CH independent Galois LFSR channels of width N behind one write port.
//   Channel c owns addresses BASE + 8*c .. BASE + 8*c + 7; even offsets
//   0/2/4/6 are POLY/SEED/CTRL/COUNT, odd offsets are ignored.
//
//   Ports:
//     clock, reset   : rising-edge clock, async active-high reset
//     W, A[15:0], D  : write enable, address, data (one register per cycle)
//     Q[CH*N-1:0]    : LFSR values, channel c at [c*N +: N]
//     busy[CH-1:0]   : channel in RUN, STEP or BURST
//     done[CH-1:0]   : one-cycle burst-complete pulse
//     lockup[CH-1:0] : channel held LFSR == 0 while active
// -----------------------------------------------------------------------------
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int          N    = 8,
    parameter int          CH   = 4,
    parameter logic [15:0] BASE = 16'h0010
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            W,
    input  logic [15:0]     A,
    input  logic [N-1:0]    D,
    output logic [CH*N-1:0] Q,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   done,
    output logic [CH-1:0]   lockup
);

    logic [31:0] rel;
    logic        in_win;
    logic [31:0] ch_sel;
    logic [2:0]  ofs;

    // Decode in 32 bits so BASE + 8*CH cannot wrap; below-BASE addresses are
    // rejected explicitly since their relative offset would underflow.
    always_comb begin
        rel    = {16'h0000, A} - {16'h0000, BASE};
        in_win = W && (A >= BASE) && (rel < 32'(CH_STRIDE * CH));
        ch_sel = rel >> 3;
        ofs    = rel[2:0];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic       sel;
        lfsr_mode_e ch_state;

        assign sel = in_win && (ch_sel == 32'(c));

        lfsr_channel #(.N(N)) u_ch (
            .clock    (clock),
            .reset    (reset),
            .we_poly  (sel && (ofs == OFS_POLY)),
            .we_seed  (sel && (ofs == OFS_SEED)),
            .we_ctrl  (sel && (ofs == OFS_CTRL)),
            .we_count (sel && (ofs == OFS_COUNT)),
            .d        (D),
            .q        (Q[c*N +: N]),
            .state    (ch_state),
            .done     (done[c]),
            .lockup   (lockup[c])
        );

        // Decoded straight from the state flop, so busy carries no
        // combinational path from the write port.
        assign busy[c] = mode_active(ch_state);
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// -----------------------------------------------------------------------------
// tb_lfsr_bank
//   Directed bench for lfsr_bank (N=8, CH=4, BASE=0x0010). A per-channel
//   model updated once per clock edge queues the expected outputs; a
//   negedge process pops and compares them. Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_lfsr_bank;

    localparam int N  = 8;
    localparam int CH = 4;
    localparam int EW = CH*N + 3*CH;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            W     = 1'b0;
    logic [15:0]     A     = '0;
    logic [N-1:0]    D     = '0;
    logic [CH*N-1:0] Q;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic [CH-1:0]   lockup;

    int total = 0;
    int bad   = 0;

    lfsr_bank #(.N(N), .CH(CH), .BASE(16'h0010)) dut (
        .clock  (clock),
        .reset  (reset),
        .W      (W),
        .A      (A),
        .D      (D),
        .Q      (Q),
        .busy   (busy),
        .done   (done),
        .lockup (lockup)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- model ----------------
    // mode: 0 idle, 1 step, 2 run, 3 burst (the CTRL write codes)
    logic [N-1:0] m_poly [CH];
    logic [N-1:0] m_lfsr [CH];
    logic [N-1:0] m_count[CH];
    logic [N-1:0] m_rem  [CH];
    int           m_mode [CH];
    logic         m_done [CH];
    logic         m_lock [CH];

    logic [EW-1:0] exp_q[$];

    function automatic logic [N-1:0] adv(input logic [N-1:0] v, input logic [N-1:0] p);
        return (v >> 1) ^ (v[0] ? p : '0);
    endfunction

    function automatic logic [EW-1:0] model_out();
        logic [CH*N-1:0] q;
        logic [CH-1:0]   b;
        logic [CH-1:0]   dn;
        logic [CH-1:0]   lk;
        for (int c = 0; c < CH; c++) begin
            q[c*N +: N] = m_lfsr[c];
            b[c]        = (m_mode[c] != 0);
            dn[c]       = m_done[c];
            lk[c]       = m_lock[c];
        end
        return {q, b, dn, lk};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_poly[c]  = '0;
            m_lfsr[c]  = '0;
            m_count[c] = '0;
            m_rem[c]   = '0;
            m_mode[c]  = 0;
            m_done[c]  = 1'b0;
            m_lock[c]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        int ch;
        int ofs;
        int rel;
        if (reset) begin
            model_clear();
            exp_q.push_back(model_out());
            return;
        end
        ch  = -1;
        ofs = -1;
        rel = int'(A) - 16;
        if (W && rel >= 0 && rel < 8*CH) begin
            ch  = rel / 8;
            ofs = rel % 8;
        end
        for (int c = 0; c < CH; c++) begin
            m_lock[c] = (m_lfsr[c] == '0) && (m_mode[c] != 0);
            m_done[c] = 1'b0;
            case (m_mode[c])
                1: begin
                    m_lfsr[c] = adv(m_lfsr[c], m_poly[c]);
                    m_mode[c] = 0;
                end
                2: m_lfsr[c] = adv(m_lfsr[c], m_poly[c]);
                3: begin
                    if (m_rem[c] == '0) begin
                        m_mode[c] = 0;
                        m_done[c] = 1'b1;
                    end else begin
                        m_lfsr[c] = adv(m_lfsr[c], m_poly[c]);
                        m_rem[c]  = m_rem[c] - 8'd1;
                        if (m_rem[c] == '0) begin
                            m_mode[c] = 0;
                            m_done[c] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (c == ch) begin
                case (ofs)
                    0: m_poly[c] = D;
                    2: m_lfsr[c] = D;
                    4: begin
                        m_mode[c] = int'(D[1:0]);
                        m_done[c] = 1'b0;
                        if (m_mode[c] == 3) m_rem[c] = m_count[c];
                    end
                    6: m_count[c] = D;
                    default: ;
                endcase
            end
        end
        exp_q.push_back(model_out());
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q",      64'(Q),      64'(e[EW-1 -: CH*N]));
            check("busy",   64'(busy),   64'(e[3*CH-1 -: CH]));
            check("done",   64'(done),   64'(e[2*CH-1 -: CH]));
            check("lockup", 64'(lockup), 64'(e[CH-1:0]));
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [N-1:0] d);
        W = 1'b1;
        A = a;
        D = d;
        tick();
        W = 1'b0;
        A = '0;
        D = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        #2;
        check("rst_q",      64'(Q),      64'd0);
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_lockup", 64'(lockup), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // channel 0: single STEP
        wr(16'h0010, 8'hB8);
        wr(16'h0012, 8'h01);
        wr(16'h0014, 8'h01);
        check("ch0_seed",      64'(Q[7:0]),  64'h01);
        check("ch0_step_busy", 64'(busy[0]), 64'd1);
        tick();
        check("ch0_step_q",    64'(Q[7:0]),  64'hB8);
        check("ch0_step_idle", 64'(busy[0]), 64'd0);
        tick();
        check("ch0_hold",      64'(Q[7:0]),  64'hB8);

        // channel 1: RUN
        wr(16'h0018, 8'hB8);
        wr(16'h001A, 8'hB8);
        wr(16'h001C, 8'h02);
        tick();
        check("ch1_run1", 64'(Q[15:8]), 64'h5C);
        tick();
        check("ch1_run2", 64'(Q[15:8]), 64'h2E);
        tick();
        check("ch1_run3", 64'(Q[15:8]), 64'h17);
        check("others",   64'({Q[31:16], Q[7:0]}), 64'h0000B8);
        wr(16'h001C, 8'h00);

        // channel 2: BURST of 3
        wr(16'h0020, 8'hB8);
        wr(16'h0022, 8'hB8);
        wr(16'h0026, 8'h03);
        wr(16'h0024, 8'h03);
        check("ch2_burst_busy", 64'(busy[2]), 64'd1);
        tick();
        tick();
        check("ch2_no_done_yet", 64'(done[2]), 64'd0);
        tick();
        check("ch2_burst_q",    64'(Q[23:16]), 64'h17);
        check("ch2_done",       64'(done[2]),  64'd1);
        check("ch2_busy_low",   64'(busy[2]),  64'd0);
        tick();
        check("ch2_done_pulse", 64'(done[2]),  64'd0);
        check("ch2_held",       64'(Q[23:16]), 64'h17);

        // channel 2: BURST with COUNT = 0
        wr(16'h0026, 8'h00);
        wr(16'h0024, 8'h03);
        check("ch2_b0_busy", 64'(busy[2]), 64'd1);
        tick();
        check("ch2_b0_done", 64'(done[2]),  64'd1);
        check("ch2_b0_q",    64'(Q[23:16]), 64'h17);
        tick();
        check("ch2_b0_pulse", 64'(done[2]), 64'd0);

        // channel 3: zero-state lockup
        wr(16'h002A, 8'h00);
        wr(16'h002C, 8'h02);
        tick();
        check("ch3_lockup",   64'(lockup[3]), 64'd1);
        check("ch3_q_zero",   64'(Q[31:24]),  64'h00);
        wr(16'h002A, 8'h01);
        check("ch3_lock_lag", 64'(lockup[3]), 64'd1);
        tick();
        check("ch3_unlock",   64'(lockup[3]), 64'd0);
        wr(16'h002C, 8'h00);

        // seed write colliding with a RUN advance on channel 0
        wr(16'h0014, 8'h02);
        tick();
        wr(16'h0012, 8'h55);
        check("seed_wins", 64'(Q[7:0]), 64'h55);
        wr(16'h0014, 8'h00);
        check("stop_adv",  64'(Q[7:0]), 64'h92);

        // ignored writes: odd offsets, above and below the window
        wr(16'h0011, 8'hAA);
        wr(16'h0013, 8'hAA);
        wr(16'h0030, 8'hAA);
        wr(16'h000F, 8'hAA);
        wr(16'h0008, 8'h03);
        check("ign_q",    64'(Q[7:0]), 64'h92);
        check("ign_busy", 64'(busy),   64'd0);
        wr(16'h0014, 8'h01);
        tick();
        check("ign_poly_kept", 64'(Q[7:0]), 64'h49);

        // reset in the middle of a 10-count burst
        wr(16'h0026, 8'h0A);
        wr(16'h0024, 8'h03);
        repeat (4) tick();
        check("mid_burst_q",    64'(Q[23:16]), 64'h64);
        check("mid_burst_busy", 64'(busy[2]),  64'd1);
        #2;
        reset = 1'b1;
        model_clear();
        exp_q.delete();
        exp_q.push_back(model_out());
        #1;
        check("arst_q",      64'(Q),      64'd0);
        check("arst_busy",   64'(busy),   64'd0);
        check("arst_done",   64'(done),   64'd0);
        check("arst_lockup", 64'(lockup), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_q",    64'(Q),    64'd0);

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
